// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one pipelined signed 8x8 multiplier among N_REQ requesters.
// One multiply is issued per cycle through a registered issue stage. A tag pipeline that
// matches the multiplier latency routes each product back to the requester that issued it.
// Optional feature: define MUL_ARB_QOS0_EN to give requester 0 absolute priority.
module mul_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_w,
  input  logic [8*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         mul_w,
  output logic [7:0]         mul_x,
  input  logic [15:0]        mul_y,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_data,
  output logic               idle
);

  localparam int unsigned IdW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // One stage for the issue register plus one per multiplier stage.
  localparam int unsigned NStg = MUL_LAT + 1;

  logic [IdW-1:0] r_ptr;
  logic [IdW-1:0] w_ptr_d;
  logic           w_accept;
  logic           w_qos_win;
  logic [IdW-1:0] w_gnt_id;
  logic [7:0]     w_sel_w;
  logic [7:0]     w_sel_x;
  logic [7:0]     r_mul_w;
  logic [7:0]     r_mul_x;
  logic [NStg-1:0] r_tag_v;
  logic [IdW-1:0]  r_tag_id [NStg];

`ifdef MUL_ARB_QOS0_EN
  // Requester 0 wins outright whenever it asks.
  assign w_qos_win = req[0];
`else
  assign w_qos_win = 1'b0;
`endif

  // Pick the first requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin : p_grant
    int unsigned idx;
    idx      = 0;
    w_accept = 1'b0;
    w_gnt_id = '0;
    gnt      = '0;
    if (w_qos_win) begin
      w_accept = 1'b1;
      w_gnt_id = '0;
    end else begin
      // With QoS enabled req[0] is low here, so the search skips requester 0 naturally.
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = (int'(r_ptr) + k) % N_REQ;
        if (!w_accept && req[IdW'(idx)]) begin
          w_accept = 1'b1;
          w_gnt_id = IdW'(idx);
        end
      end
    end
    if (w_accept) gnt[w_gnt_id] = 1'b1;
  end

  // Next pointer: one past the winner; QoS wins of requester 0 leave it untouched.
  always_comb begin : p_ptr_next
    w_ptr_d = r_ptr;
    if (w_accept && !w_qos_win) begin
      w_ptr_d = (w_gnt_id == IdW'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin : p_operand_sel
    w_sel_w = '0;
    w_sel_x = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt_id == IdW'(i)) begin
        w_sel_w = req_w[8*i +: 8];
        w_sel_x = req_x[8*i +: 8];
      end
    end
  end

  // Pointer and issue-stage registers; operands hold when nothing is accepted.
  always_ff @(posedge clk) begin : p_issue
    if (!rstn) begin
      r_ptr   <= '0;
      r_mul_w <= '0;
      r_mul_x <= '0;
    end else begin
      r_ptr <= w_ptr_d;
      if (w_accept) begin
        r_mul_w <= w_sel_w;
        r_mul_x <= w_sel_x;
      end
    end
  end

  // Tag shift register tracking which requester owns each in-flight product.
  always_ff @(posedge clk) begin : p_tag_pipe
    if (!rstn) begin
      r_tag_v <= '0;
      for (int unsigned i = 0; i < NStg; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v     <= {r_tag_v[NStg-2:0], w_accept};
      r_tag_id[0] <= w_gnt_id;
      for (int unsigned i = 1; i < NStg; i++) r_tag_id[i] <= r_tag_id[i-1];
    end
  end

  // Decode the oldest tag into the one-hot response strobe.
  always_comb begin : p_rsp
    rsp_valid = '0;
    if (r_tag_v[NStg-1]) rsp_valid[r_tag_id[NStg-1]] = 1'b1;
  end

  assign mul_w    = r_mul_w;
  assign mul_x    = r_mul_x;
  assign rsp_data = mul_y;
  assign idle     = ~|req & ~|r_tag_v;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model (grant search over a pointer, a queue of
// expected responses keyed by due cycle). The multiplier is modelled here as a plain
// 5-deep product pipeline with no reset.
module tb_mul_arbiter;

  localparam int NReq   = 4;
  localparam int MulLat = 5;
`ifdef MUL_ARB_QOS0_EN
  localparam bit QosEn = 1'b1;
`else
  localparam bit QosEn = 1'b0;
`endif

  logic              clk;
  logic              rstn;
  logic [NReq-1:0]   req;
  logic [8*NReq-1:0] req_w;
  logic [8*NReq-1:0] req_x;
  logic [NReq-1:0]   gnt;
  logic [7:0]        mul_w;
  logic [7:0]        mul_x;
  logic [15:0]       mul_y;
  logic [NReq-1:0]   rsp_valid;
  logic [15:0]       rsp_data;
  logic              idle;

  mul_arbiter #(.N_REQ(NReq), .MUL_LAT(MulLat)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_w     (req_w),
    .req_x     (req_x),
    .gnt       (gnt),
    .mul_w     (mul_w),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: fixed latency, no stall, no reset.
  logic [15:0] mul_pipe [MulLat];
  always @(posedge clk) begin
    mul_pipe[0] <= 16'(int'($signed(mul_w)) * int'($signed(mul_x)));
    for (int i = 1; i < MulLat; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign mul_y = mul_pipe[MulLat-1];

  typedef struct {
    int          due;
    int          id;
    logic [15:0] prod;
  } rsp_t;

  rsp_t exp_q[$];
  int   m_ptr;
  int   cyc;
  int   n_checks;
  int   n_fails;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_grant(input logic [NReq-1:0] r, input int p);
    if (QosEn && r[0]) return 0;
    for (int k = 0; k < NReq; k++) begin
      int i;
      i = (p + k) % NReq;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Drive one cycle, check outputs at the falling edge, advance the model at the rising edge.
  task automatic run_cycle(input logic [NReq-1:0] r, input logic [31:0] w, input logic [31:0] x,
                           input logic rn);
    int          g;
    logic [3:0]  eg;
    logic [3:0]  ev;
    logic [15:0] ed;
    logic [7:0]  wa;
    logic [7:0]  xa;
    bit          busy;
    req   = r;
    req_w = w;
    req_x = x;
    rstn  = rn;
    @(negedge clk);
    g  = exp_grant(r, m_ptr);
    eg = (g >= 0) ? 4'(1 << g) : 4'b0;
    check_val("gnt", 32'(gnt), 32'(eg));
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    busy = (exp_q.size() > 0);
    ev   = '0;
    ed   = '0;
    if (busy && exp_q[0].due == cyc) begin
      ev = 4'(1 << exp_q[0].id);
      ed = exp_q[0].prod;
    end
    check_val("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev != 0) check_val("rsp_data", 32'(rsp_data), 32'(ed));
    check_val("idle", 32'(idle), 32'(r == 0 && !busy));
    @(posedge clk);
    if (!rn) begin
      m_ptr = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      wa = 8'(w >> (8 * g));
      xa = 8'(x >> (8 * g));
      exp_q.push_back('{due: cyc + 1 + MulLat, id: g,
                        prod: 16'(int'($signed(wa)) * int'($signed(xa)))});
      if (!(QosEn && g == 0)) m_ptr = (g + 1) % NReq;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(4'b0000, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    cyc      = 0;
    m_ptr    = 0;
    rstn     = 1'b0;
    req      = '0;
    req_w    = '0;
    req_x    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_mul_w", 32'(mul_w), 32'h0);
    check_val("rst_mul_x", 32'(mul_x), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_idle", 32'(idle), 32'h1);

    // Single request: 3 * -5 = 0xFFF1 returned to requester 0 six cycles later.
    run_cycle(4'b0001, 32'h0000_0003, 32'h0000_00FB, 1'b1);
    idle_cycles(8);

    // Fairness from ptr=0 with all four requesting for 8 cycles.
    run_cycle(4'b0000, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_cycle(4'b1111, {8'(i + 4), 8'(i + 3), 8'(i + 2), 8'(i + 1)},
                {8'(-i - 1), 8'(i * 3), 8'(7), 8'(-5)}, 1'b1);
    idle_cycles(7);

    // Extremes issued back-to-back to distinct requesters.
    run_cycle(4'b0001, 32'h0000_0080, 32'h0000_0080, 1'b1);
    run_cycle(4'b0010, 32'h0000_8000, 32'h0000_7F00, 1'b1);
    run_cycle(4'b0100, 32'h007F_0000, 32'h007F_0000, 1'b1);
    run_cycle(4'b1000, 32'h0000_0000, 32'hFF00_0000, 1'b1);
    idle_cycles(7);

    // Sparse requests and pointer wrap.
    run_cycle(4'b1000, 32'h0500_0000, 32'h0600_0000, 1'b1);
    run_cycle(4'b1001, 32'h0900_00F9, 32'h0A00_0002, 1'b1);
    run_cycle(4'b1111, 32'h0403_0201, 32'h0807_0605, 1'b1);
    idle_cycles(7);

    // Reset mid-flight: three multiplies, then a one-cycle reset two cycles later.
    run_cycle(4'b0111, 32'h0011_2233, 32'h0044_5566, 1'b1);
    run_cycle(4'b0111, 32'h0011_2233, 32'h0044_5566, 1'b1);
    run_cycle(4'b0111, 32'h0011_2233, 32'h0044_5566, 1'b1);
    idle_cycles(1);
    run_cycle(4'b0000, 32'h0, 32'h0, 1'b0);
    run_cycle(4'b0100, 32'h000C_0000, 32'h00F3_0000, 1'b1);
    idle_cycles(8);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      run_cycle(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 59) != 0));
    idle_cycles(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
